// File: rtl/uart_fifo_core_if.sv
// uart_fifo_core_if: byte-stream bundle between the UART core and user logic.
// master = user side (drives TX bytes, accepts RX bytes), slave = the core.
interface uart_fifo_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_parity_err;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_parity_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX/RX FIFOs behind a valid/ready bus.
// Optional parity bit is compiled in with the macro UART_PARITY_EN; without it
// no parity bit is sent or expected and rx_parity_err stays low.
module uart_fifo_core #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            uart_rx,
    output logic            uart_tx,
    uart_fifo_core_if.slave bus
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int TAW  = $clog2(TX_DEPTH);
    localparam int RAW  = $clog2(RX_DEPTH);
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    // ---------------------------------------------------------------- TX FIFO
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]       tx_wr_q, tx_rd_q;
    logic [TAW:0]         tx_cnt_q;
    logic                 tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign bus.tx_ready = (tx_cnt_q != (TAW+1)'(TX_DEPTH));
    assign tx_push      = bus.tx_valid && bus.tx_ready;
    assign tx_head      = tx_mem[tx_rd_q];

    // TX storage: written on push, no reset needed for the data itself
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= bus.tx_data;
    end

    // TX pointers and fill level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        end
    end

    // ---------------------------------------------------------------- TX FSM
    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_tick_q, tx_tick_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_tick_q == CW'(DIV - 1));
    assign uart_tx    = tx_line_q;

    // TX state register; line returns high immediately on reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q <= S_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX next state: the line value for the next bit is registered at each bit boundary
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_tick_d = '0;
                tx_line_d = 1'b1;
                if (tx_cnt_q != '0) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = tx_head;
                    tx_line_d  = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_byte_q[0];
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_tick_d = '0;
                    if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                        if (PAR_EN) begin
                            tx_line_d  = (^tx_byte_q) ^ PARITY_ODD;
                            tx_state_d = S_PARITY;
                        end else begin
                            tx_line_d  = 1'b1;
                            tx_state_d = S_STOP;
                        end
                    end else begin
                        tx_bit_d  = tx_bit_q + 1'b1;
                        tx_line_d = tx_byte_q[tx_bit_q + 1'b1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_bit_end) begin
                    tx_tick_d  = '0;
                    tx_line_d  = 1'b1;
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    tx_tick_d = '0;
                    // back-to-back frames: no idle gap when more data is queued
                    if (tx_cnt_q != '0) begin
                        tx_pop     = 1'b1;
                        tx_byte_d  = tx_head;
                        tx_line_d  = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_line_d  = 1'b1;
                tx_state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- RX path
    logic rx_meta_q, rx_sync_q;

    // Two-flop synchroniser for the asynchronous serial input, idling high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]       rx_wr_q, rx_rd_q, rx_rd_d;
    logic [RAW:0]         rx_cnt_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_push, rx_pop, rx_valid, rx_full;

    state_t               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_tick_q, rx_tick_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_par_bad_q, rx_par_bad_d;
    logic                 rx_frame_q, rx_frame_d;
    logic                 rx_over_q, rx_over_d;
    logic                 rx_perr_q, rx_perr_d;

    assign rx_valid          = (rx_cnt_q != '0);
    assign rx_full           = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
    assign rx_pop            = rx_valid && bus.rx_ready;
    assign rx_rd_d           = rx_pop ? rx_rd_q + 1'b1 : rx_rd_q;
    assign bus.rx_valid      = rx_valid;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_frame_err  = rx_frame_q;
    assign bus.rx_overrun    = rx_over_q;
    assign bus.rx_parity_err = rx_perr_q;

    // RX storage with registered head; a write landing on the new head is forwarded
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_byte_q;
        rx_data_q <= (rx_push && (rx_wr_q == rx_rd_d)) ? rx_byte_q : rx_mem[rx_rd_d];
    end

    // RX pointers, fill level and error pulse registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            rx_frame_q <= 1'b0;
            rx_over_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            rx_rd_q    <= rx_rd_d;
            rx_cnt_q   <= rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            rx_frame_q <= rx_frame_d;
            rx_over_q  <= rx_over_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q   <= S_IDLE;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_byte_q    <= '0;
            rx_par_bad_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_byte_q    <= rx_byte_d;
            rx_par_bad_q <= rx_par_bad_d;
        end
    end

    // RX next state: mid-bit sampling, byte delivery and error classification at stop
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_tick_d    = rx_tick_q + 1'b1;
        rx_bit_d     = rx_bit_q;
        rx_byte_d    = rx_byte_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push      = 1'b0;
        rx_frame_d   = 1'b0;
        rx_over_d    = 1'b0;
        rx_perr_d    = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                rx_tick_d    = '0;
                rx_par_bad_d = 1'b0;
                if (!rx_sync_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_tick_q == CW'(DIV / 2 - 1)) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    // a line already back high mid-start-bit was only a glitch
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick_q == CW'(DIV - 1)) begin
                    rx_tick_d = '0;
                    rx_byte_d = {rx_sync_q, rx_byte_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BW'(DATA_BITS - 1)) begin
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_tick_q == CW'(DIV - 1)) begin
                    rx_tick_d    = '0;
                    rx_par_bad_d = PAR_EN && (rx_sync_q != ((^rx_byte_q) ^ PARITY_ODD));
                    rx_state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_tick_q == CW'(DIV - 1)) begin
                    rx_tick_d = '0;
                    rx_perr_d = rx_par_bad_q;
                    if (rx_sync_q) begin
                        rx_state_d = S_IDLE;
                        if (!rx_par_bad_q) begin
                            // a pop in the same cycle frees the slot of a full FIFO
                            if (rx_full && !rx_pop) rx_over_d = 1'b1;
                            else                    rx_push   = 1'b1;
                        end
                    end else begin
                        rx_frame_d = 1'b1;
                        rx_state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // wait out a break condition before hunting for the next start bit
                rx_tick_d = '0;
                if (rx_sync_q) rx_state_d = S_IDLE;
            end
            default: begin
                rx_tick_d  = '0;
                rx_state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: randomized scoreboard bench for uart_fifo_core at default
// parameters. Expected RX bytes are queued by the stimulus; a monitor pops and
// compares every accepted rx_data beat and counts error pulses.
`timescale 1ns/1ps
module tb_uart_fifo_core;
    localparam int DB  = 8;
    localparam int DIV = 27000000 / 115200;
`ifdef UART_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif
    localparam int FRAME = NBITS * DIV;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    logic uart_tx;
    logic uart_rx;

    int vectors     = 0;
    int miscompares = 0;
    int frame_cnt   = 0;
    int over_cnt    = 0;
    int par_cnt     = 0;
    logic [7:0] exp_q[$];

    uart_fifo_core_if #(.DATA_BITS(DB)) bus ();

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_fifo_core #(
        .CLK_HZ(27000000), .BAUD(115200), .DATA_BITS(DB),
        .TX_DEPTH(16), .RX_DEPTH(16), .PARITY_ODD(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .uart_tx(uart_tx), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial frame as the line should carry it, index 0 = start bit
    function automatic logic [15:0] make_frame(input logic [7:0] d, input logic stop);
        logic [15:0] f;
        f        = '1;
        f[0]     = 1'b0;
        f[DB:1]  = d;
`ifdef UART_PARITY_EN
        f[DB+1]  = ^d;
`endif
        f[NBITS-1] = stop;
        return f;
    endfunction

    task automatic send_bits(input logic [15:0] f);
        for (int i = 0; i < NBITS; i++) begin
            rx_drv = f[i];
            step(DIV);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        int w;
        w = 0;
        while (!bus.tx_ready && w < 5000) begin
            step(1);
            w++;
        end
        if (w >= 5000) check("tx_ready_timeout", 32'd0, 32'd1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        $display("tx push %02h", b);
        step(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < limit) begin
            step(1);
            w++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard compare on each accepted byte, pulse counting
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rx_frame_err)  frame_cnt++;
            if (bus.rx_overrun)    over_cnt++;
            if (bus.rx_parity_err) par_cnt++;
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rx: got %02h expected none at %0t", bus.rx_data, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    $display("rx pop %02h (expect %02h)", bus.rx_data, e);
                    check("rx_data", bus.rx_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f;
        logic [7:0]  b;
        int f0, o0, p0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;

        // Reset state
        step(3);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_pulses", {bus.rx_frame_err, bus.rx_overrun, bus.rx_parity_err}, 0);
        reset_n = 1'b1;
        step(2);

        // 1: single frame timing, start bit two cycles after the push cycle
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        $display("tx push 55");
        step(1);
        bus.tx_valid = 1'b0;
        check("t1_before_start", uart_tx, 1);
        step(1);
        f = make_frame(8'h55, 1'b1);
        for (int t = 0; t < FRAME; t++) begin
            check("t1_line", uart_tx, f[t / DIV]);
            step(1);
        end
        check("t1_idle_after", uart_tx, 1);
        check("t1_tx_ready", bus.tx_ready, 1);

        // 2: loopback, back-to-back frames with no idle gap
        loop_en      = 1'b1;
        bus.rx_ready = 1'b1;
        step(20);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA3; step(1);
        bus.tx_data  = 8'h00; step(1);
        bus.tx_data  = 8'hFF; step(1);
        bus.tx_valid = 1'b0;
        // now one cycle after the first start bit began
        step(FRAME - 2);
        check("t2_stop1", uart_tx, 1);
        step(1);
        check("t2_start2", uart_tx, 0);
        step(FRAME - 1);
        check("t2_stop2", uart_tx, 1);
        step(1);
        check("t2_start3", uart_tx, 0);
        drain(2 * FRAME + 1000);
        check("t2_frame_err", frame_cnt, 0);
        check("t2_overrun", over_cnt, 0);
        check("t2_parity_err", par_cnt, 0);

        // 3: 17 random frames with consumer stalled -> 16 kept, 1 overrun
        bus.rx_ready = 1'b0;
        o0 = over_cnt;
        f0 = frame_cnt;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 16) exp_q.push_back(b);
            push_tx(b);
        end
        step(FRAME + 200);
        check("t3_rx_valid_early", bus.rx_valid, 1);
        check("t3_no_overrun_yet", over_cnt, o0);
        step(16 * FRAME);
        check("t3_overrun_once", over_cnt, o0 + 1);
        check("t3_no_frame_err", frame_cnt, f0);
        bus.rx_ready = 1'b1;
        drain(200);
        step(5);
        check("t3_rx_empty", bus.rx_valid, 0);

        // 4: stop bit low, held low as a break, then a clean frame
        loop_en = 1'b0;
        step(100);
        f0 = frame_cnt;
        send_bits(make_frame(8'h3C, 1'b0));
        step(5000);
        check("t4_frame_err", frame_cnt, f0 + 1);
        check("t4_nothing_pushed", bus.rx_valid, 0);
        rx_drv = 1'b1;
        step(300);
        exp_q.push_back(8'h11);
        send_bits(make_frame(8'h11, 1'b1));
        drain(1000);
        check("t4_frame_err_after", frame_cnt, f0 + 1);

        // 5: 50-cycle glitch is ignored, receiver still works afterwards
        f0 = frame_cnt; o0 = over_cnt; p0 = par_cnt;
        rx_drv = 1'b0;
        step(50);
        rx_drv = 1'b1;
        step(3000);
        check("t5_glitch_no_push", bus.rx_valid, 0);
        check("t5_glitch_no_pulse", frame_cnt + over_cnt + par_cnt, f0 + o0 + p0);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        send_bits(make_frame(b, 1'b1));
        drain(1000);

        // 5b: reset in the middle of a TX frame with more bytes queued
        for (int i = 0; i < 3; i++) push_tx(8'($urandom_range(0, 255)));
        step(500);
        reset_n = 1'b0;
        step(1);
        check("t5_rst_uart_tx", uart_tx, 1);
        check("t5_rst_tx_ready", bus.tx_ready, 1);
        check("t5_rst_rx_valid", bus.rx_valid, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(FRAME / 4);
            check("t5_line_idle_after_rst", uart_tx, 1);
        end

`ifdef UART_PARITY_EN
        // 6: corrupted parity bit, then the correct frame
        p0 = par_cnt;
        f = make_frame(8'h07, 1'b1);
        f[DB+1] = ~f[DB+1];
        send_bits(f);
        step(200);
        check("t6_parity_err", par_cnt, p0 + 1);
        check("t6_no_push", bus.rx_valid, 0);
        exp_q.push_back(8'h07);
        send_bits(make_frame(8'h07, 1'b1));
        drain(1000);
        check("t6_parity_err_after", par_cnt, p0 + 1);
`else
        check("parity_err_tied_low", par_cnt, 0);
`endif

        step(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
